shift_sequencer: RTL

Multi-cycle shift controller that sequences the team's single-bit `shifter` block to perform shifts of 0–15 positions on a 16-bit operand. It instantiates one `shifter` and applies it once per clock to a held working register, using a start/busy/done handshake. It sits beside the datapath ALU stage and serves any requester that needs multi-position shifts without a barrel shifter.

---
 rtl/shift_sequencer_if.sv | 12 +
 rtl/shift_sequencer.sv | 51 +++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: start/busy/done request handshake and operand/result bus
interface shift_sequencer_if;
  logic        start;
  logic [15:0] din;
  logic [3:0]  amt;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [15:0] dout;
  modport master (output start, din, amt, op, input busy, done, dout);
  modport slave (input start, din, amt, op, output busy, done, dout);
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 0-15 position shifter built on one single-bit shifter pass per clock
module shifter (
  input  logic [15:0] in,
  input  logic [1:0]  shift,
  output logic [15:0] sout
);
  always_comb sout = shift == 2'b01 ? {in[14:0], 1'b0} :
                     shift == 2'b10 ? {1'b0, in[15:1]} :
                     shift == 2'b11 ? {in[15], in[15:1]} : in;
endmodule

module shift_sequencer (
  input logic             clk,
  input logic             reset,
  shift_sequencer_if.slave sif
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state, next;
  logic [15:0] work, sout;
  logic [3:0]  cnt;
  logic [1:0]  op_q;
  logic        accept;
  shifter u_shifter (.in(work), .shift(op_q), .sout(sout));
  assign accept   = state == IDLE && sif.start;
  assign sif.busy = state != IDLE;
  assign sif.done = state == DONE;
  assign sif.dout = work;
  always_comb begin
    next = IDLE;
    if (state == IDLE) next = sif.start ? ((sif.amt == 4'd0 || sif.op == 2'b00) ? DONE : SHIFT) : IDLE;
    else if (state == SHIFT) next = cnt == 4'd1 ? DONE : SHIFT;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      op_q  <= '0;
    end else begin
      state <= next;
      if (accept) begin
        work <= sif.din;
        cnt  <= sif.amt;
        op_q <= sif.op;
      end else if (state == SHIFT) begin
        work <= sout;
        cnt  <= cnt - 4'd1;
      end
    end
  end
endmodule
